enc_8to3_pending: RTL and testbench

ENC_8TO3_PENDING -- requirements
Module: enc_8to3_pending

---
 rtl/enc_pkg.sv | 10 +
 rtl/pri_sel_8to3.sv | 30 +++
 rtl/enc_8to3_pending.sv | 98 +++++++++
 tb/tb_enc_8to3_pending.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants and FSM state type for the 8-to-3 pending-request encoder.
package enc_pkg;
    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/pri_sel_8to3.sv
// Combinational priority selector: picks one set bit of pending, lowest or highest index first.
module pri_sel_8to3
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0]  pending,
    input  logic              prio_lsb,
    output logic [CODE_W-1:0] index,
    output logic              found
);

    always_comb begin
        index = '0;
        found = |pending;
        // Scan toward the winning end so the last hit overwrites earlier ones.
        if (prio_lsb) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    index = CODE_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pending[i]) begin
                    index = CODE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/enc_8to3_pending.sv
// Edge-captured request encoder: latches rising edges of req as pending bits and
// presents them one at a time as a binary code with a valid/ack handshake.
module enc_8to3_pending
    import enc_pkg::*;
#(
    parameter bit PRIO_LSB = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              any_pending,
    output logic              overflow
);

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    req_q, req_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                overflow_q, overflow_d;

    logic [N_REQ-1:0]    edge_set;
    logic [N_REQ-1:0]    clr_mask;
    logic                ack_take;
    logic [CODE_W-1:0]   sel_index;
    logic                sel_found;

    assign ack_take = (state_q == PRESENT) && ack;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_bit
            assign edge_set[gi] = en && req[gi] && !req_q[gi];
            assign clr_mask[gi] = ack_take && (code_q == CODE_W'(gi));
        end
    endgenerate

    pri_sel_8to3 u_pri_sel (
        .pending  (pending_q),
        .prio_lsb (PRIO_LSB),
        .index    (sel_index),
        .found    (sel_found)
    );

    always_comb begin
        req_d      = req;
        // Set beats clear, so a re-request during its own ack stays pending.
        pending_d  = (pending_q & ~clr_mask) | edge_set;
        overflow_d = overflow_q | (|(edge_set & pending_q & ~clr_mask));
        state_d    = state_q;
        code_d     = code_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = PRESENT;
                    code_d  = sel_index;
                end else begin
                    code_d  = '0;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d = IDLE;
                    code_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            pending_q  <= '0;
            code_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pending_q  <= pending_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end

    assign code        = code_q;
    assign valid       = (state_q == PRESENT);
    assign any_pending = |pending_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_enc_8to3_pending.sv
// Directed bench for enc_8to3_pending; two instances cover both priority orders.
module tb_enc_8to3_pending;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ack;

    logic [2:0] code_l, code_m;
    logic       valid_l, valid_m;
    logic       anyp_l, anyp_m;
    logic       ovf_l, ovf_m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    enc_8to3_pending #(.PRIO_LSB(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .code(code_l), .valid(valid_l), .any_pending(anyp_l), .overflow(ovf_l)
    );

    enc_8to3_pending #(.PRIO_LSB(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .code(code_m), .valid(valid_m), .any_pending(anyp_m), .overflow(ovf_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect a presentation on the LSB instance.
    task automatic expect_code(input string tag, input logic [2:0] c);
        check({tag, "_valid"}, {7'd0, valid_l}, 8'd1);
        check({tag, "_code"}, {5'd0, code_l}, {5'd0, c});
        $display("step %s: valid=%0d code=%0d", tag, valid_l, code_l);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ackvalid"}, {7'd0, valid_l}, 8'd0);
        check({tag, "_ackcode"}, {5'd0, code_l}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 8'h00; ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", {7'd0, valid_l}, 8'd0);
        check("rst_code", {5'd0, code_l}, 8'd0);
        check("rst_ovf", {7'd0, ovf_l}, 8'd0);
        check("rst_anyp", {7'd0, anyp_l}, 8'd0);

        // Case 1: single request, latency two edges
        req = 8'h04; tick(); req = 8'h00;
        check("c1_anyp", {7'd0, anyp_l}, 8'd1);
        check("c1_early_valid", {7'd0, valid_l}, 8'd0);
        tick();
        expect_code("c1", 3'd2);
        do_ack("c1");
        check("c1_anyp_end", {7'd0, anyp_l}, 8'd0);

        // Stray ack while idle has no effect
        ack = 1'b1; tick(); ack = 1'b0;
        check("idle_ack_valid", {7'd0, valid_l}, 8'd0);
        check("idle_ack_anyp", {7'd0, anyp_l}, 8'd0);

        // Case 2: three bits, both priority orders
        req = 8'b1001_0010; tick(); req = 8'h00;
        ack = 1'b1; tick(); ack = 1'b0;   // ack while still IDLE is ignored
        expect_code("c2a", 3'd1);
        check("c2a_msb", {5'd0, code_m}, 8'd7);
        do_ack("c2a"); tick();
        expect_code("c2b", 3'd4);
        check("c2b_msb", {5'd0, code_m}, 8'd4);
        do_ack("c2b"); tick();
        expect_code("c2c", 3'd7);
        check("c2c_msb", {5'd0, code_m}, 8'd1);
        do_ack("c2c");
        check("c2_anyp_l", {7'd0, anyp_l}, 8'd0);
        check("c2_anyp_m", {7'd0, anyp_m}, 8'd0);

        // Case 3: higher-priority arrival does not preempt
        req = 8'h20; tick(); req = 8'h00; tick();
        expect_code("c3a", 3'd5);
        req = 8'h01; tick(); req = 8'h00;
        expect_code("c3b", 3'd5);
        tick();
        expect_code("c3c", 3'd5);
        do_ack("c3"); tick();
        expect_code("c3d", 3'd0);
        do_ack("c3d");

        // Case 4: duplicate edge while pending sets overflow, one delivery
        req = 8'h08; tick(); req = 8'h00; tick();
        expect_code("c4a", 3'd3);
        check("c4_ovf_before", {7'd0, ovf_l}, 8'd0);
        req = 8'h08; tick(); req = 8'h00;
        check("c4_ovf", {7'd0, ovf_l}, 8'd1);
        expect_code("c4b", 3'd3);
        do_ack("c4");
        check("c4_anyp", {7'd0, anyp_l}, 8'd0);
        tick();
        check("c4_no_second", {7'd0, valid_l}, 8'd0);
        check("c4_ovf_sticky", {7'd0, ovf_l}, 8'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("c4_ovf_rst", {7'd0, ovf_l}, 8'd0);

        // Case 5: edge coincides with ack of the same bit
        req = 8'h40; tick(); req = 8'h00; tick();
        expect_code("c5a", 3'd6);
        req = 8'h40;
        do_ack("c5");
        req = 8'h00;
        check("c5_anyp", {7'd0, anyp_l}, 8'd1);
        check("c5_ovf", {7'd0, ovf_l}, 8'd0);
        tick();
        expect_code("c5b", 3'd6);
        do_ack("c5b");
        check("c5_anyp_end", {7'd0, anyp_l}, 8'd0);

        // en=0: new edges ignored, already pending bit still delivered
        req = 8'h02; tick(); req = 8'h00; en = 1'b0;
        req = 8'h10; tick(); req = 8'h00;
        expect_code("en0a", 3'd1);
        do_ack("en0"); tick();
        check("en0_no_new", {7'd0, valid_l}, 8'd0);
        check("en0_anyp", {7'd0, anyp_l}, 8'd0);
        en = 1'b1;

        // Case 6: reset mid-presentation with req held high
        req = 8'h04; tick(); tick();
        expect_code("c6a", 3'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("c6_rst_valid", {7'd0, valid_l}, 8'd0);
        check("c6_rst_anyp", {7'd0, anyp_l}, 8'd0);
        check("c6_rst_ovf", {7'd0, ovf_l}, 8'd0);
        tick();
        check("c6_edge_anyp", {7'd0, anyp_l}, 8'd1);
        check("c6_edge_valid", {7'd0, valid_l}, 8'd0);
        tick();
        expect_code("c6b", 3'd2);
        do_ack("c6"); tick();
        check("c6_once", {7'd0, valid_l}, 8'd0);
        check("c6_anyp_end", {7'd0, anyp_l}, 8'd0);
        req = 8'h00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
